// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, PC command codes and fetch state encodings
package cpu_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam logic [1:0] PC_HOLD   = 2'b00;
    localparam logic [1:0] PC_INC    = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_BRANCH = 2'b11;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FAULT} fetch_state_t;
endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC selection and JAL link value
import cpu_pkg::*;
module pc_next_calc #(
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [1:0]        pcEn,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [7:0]        branch_disp,
    output logic [ADDR_W-1:0] next_pc,
    output logic [ADDR_W-1:0] link_pc
);
    logic [ADDR_W-1:0] disp_ext;
    always_comb begin
        disp_ext = {{(ADDR_W-8){branch_disp[7]}}, branch_disp};
        link_pc  = pc + 1'b1;
        next_pc  = pcEn == PC_INC    ? link_pc :
                   pcEn == PC_JUMP   ? jump_target :
                   pcEn == PC_BRANCH ? pc + disp_ext : pc;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns PC and IR, applies PC commands and runs the
// handshaked instruction-memory read with a timeout fault
import cpu_pkg::*;
module fetch_unit #(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                DATA_W   = cpu_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [1:0]        pcEn,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [7:0]        branch_disp,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_pc,
    output logic              inst_valid,
    output logic              fetch_err
);
    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);
    fetch_state_t      state, state_n;
    logic [7:0]        wait_cnt;
    logic              pending, go, issue, timeout;
    logic [ADDR_W-1:0] next_pc;

    pc_next_calc #(.ADDR_W(ADDR_W)) u_pc_next (
        .pc(pc), .pcEn(pcEn), .jump_target(jump_target),
        .branch_disp(branch_disp), .next_pc(next_pc), .link_pc(link_pc)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= ST_IDLE;
        else        state <= state_n;

    always_comb begin
        go      = fetch_req | pending;
        issue   = state == ST_IDLE && go && pcEn == PC_HOLD;
        timeout = state == ST_WAIT && !mem_ack && wait_cnt == LAST_WAIT;
        state_n = issue                        ? ST_WAIT :
                  state == ST_WAIT && mem_ack  ? ST_IDLE :
                  timeout                      ? ST_FAULT : state;
    end

    // A PC command in the same cycle as a request wins; the request is deferred via pending
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            instruction <= '0;
            mem_addr    <= '0;
            mem_rd      <= 1'b0;
            inst_valid  <= 1'b0;
            fetch_err   <= 1'b0;
            pending     <= 1'b0;
            wait_cnt    <= '0;
        end else if (state == ST_IDLE) begin
            if (pcEn != PC_HOLD) begin
                pc <= next_pc;
                if (go) pending <= 1'b1;
            end else if (go) begin
                mem_addr   <= pc;
                mem_rd     <= 1'b1;
                inst_valid <= 1'b0;
                wait_cnt   <= '0;
            end
        end else if (state == ST_WAIT) begin
            if (mem_ack) begin
                instruction <= mem_rdata;
                mem_rd      <= 1'b0;
                inst_valid  <= 1'b1;
                pending     <= 1'b0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
                if (timeout) begin
                    mem_rd    <= 1'b0;
                    fetch_err <= 1'b1;
                end
            end
        end
    end
endmodule
